sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with standard or first-word-fall-through read
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csen_n,
    input  logic                  clr,
    input  logic                  wren_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rden_n,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH:0] C_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_data_ld;

    // A read is only accepted from stored words, so a write into an empty FIFO never bypasses to a same-cycle read.
    assign w_wr_req = !csen_n && !wren_n;
    assign w_rd_req = !csen_n && !rden_n;
    assign w_rd_ok  = w_rd_req && !r_empty;
    assign w_wr_ok  = w_wr_req && (!r_full || w_rd_ok);

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_wr_ok) begin
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   w_count_nxt = r_count + C_ONE;
                2'b01:   w_count_nxt = r_count - C_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // FWFT keeps data_o registered on the next head word; a write landing in the head slot is forwarded from data_i.
    always_comb begin
        w_data_nxt = r_data_o;
        w_data_ld  = 1'b0;
        if (FWFT != 0) begin
            if (!clr && (w_count_nxt != '0)) begin
                w_data_ld = 1'b1;
                if (w_wr_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
                    w_data_nxt = data_i;
                end else begin
                    w_data_nxt = r_mem[w_rd_ptr_nxt];
                end
            end
        end else begin
            if (!clr && w_rd_ok) begin
                w_data_ld  = 1'b1;
                w_data_nxt = r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && w_wr_ok) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data_o <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= C_AFULL);
            r_aempty <= (w_count_nxt <= C_AEMPTY);
            r_ovf    <= !clr && w_wr_req && !w_wr_ok;
            r_udf    <= !clr && w_rd_req && r_empty;
            if (w_data_ld) begin
                r_data_o <= w_data_nxt;
            end
        end
    end

    assign data_o = r_data_o;
    assign full   = r_full;
    assign empty  = r_empty;
    assign afull  = r_afull;
    assign aempty = r_aempty;
    assign count  = r_count;
    assign ovf    = r_ovf;
    assign udf    = r_udf;

endmodule
